// File: rtl/selen_wb_sram_pkg.sv
// selen_wb_sram_pkg: shared types and constants for the Wishbone SRAM slave.
//   WB_COM_AWIDTH / WB_COM_DWIDTH : crossbar address / data widths
//   SRAM_MAX_LATENCY              : deepest response pipeline supported
//   sram_state_e                  : controller states (init-clear, run)
//   sram_rsp_t                    : one response pipeline stage
package selen_wb_sram_pkg;

  localparam int unsigned WB_COM_AWIDTH    = 32;
  localparam int unsigned WB_COM_DWIDTH    = 32;
  localparam int unsigned SRAM_MAX_LATENCY = 4;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } sram_state_e;

  typedef struct packed {
    logic                     valid;
    logic                     err;
    logic [WB_COM_DWIDTH-1:0] data;
  } sram_rsp_t;

endpackage

// File: rtl/selen_wb_sram_rsp_pipe.sv
// selen_wb_sram_rsp_pipe: fixed-length shift register of response stages.
//   i_clk   : clock
//   i_flush : synchronous clear of every stage (abort or reset)
//   i_stage : stage-0 load value, sampled every edge
//   o_stage : last stage, drives the bus response
module selen_wb_sram_rsp_pipe
  import selen_wb_sram_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic      i_clk,
  input  logic      i_flush,
  input  sram_rsp_t i_stage,
  output sram_rsp_t o_stage
);

  sram_rsp_t r_stage [LATENCY];

  always_ff @(posedge i_clk) begin
    if (i_flush) begin
      for (int k = 0; k < LATENCY; k++) begin
        r_stage[k] <= '0;
      end
    end else begin
      r_stage[0] <= i_stage;
      for (int k = 1; k < LATENCY; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  assign o_stage = r_stage[LATENCY-1];

endmodule

// File: rtl/selen_wb_sram_slave.sv
// selen_wb_sram_slave: pipelined Wishbone B4 slave in front of an on-chip SRAM.
// Clears the whole array after reset, then accepts one request per cycle and
// answers in order after LATENCY cycles.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   wb_adr_i/dat_i/sel_i: byte address, write data, byte lane enables
//   wb_cyc_i/stb_i/we_i : cycle, strobe, write
//   wb_dat_o            : read data, valid with wb_ack_o (0 for writes)
//   wb_stall_o          : high while clearing or in reset
//   wb_ack_o / wb_err_o : completion / error completion
// Build option: define SELEN_WB_SRAM_ERR_EN to answer out-of-window requests
// with wb_err_o; otherwise addresses wrap modulo the window.
module selen_wb_sram_slave
  import selen_wb_sram_pkg::*;
#(
  parameter logic [WB_COM_AWIDTH-1:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned              DEPTH     = 256,
  parameter int unsigned              LATENCY   = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [WB_COM_AWIDTH-1:0]   wb_adr_i,
  input  logic [WB_COM_DWIDTH-1:0]   wb_dat_i,
  input  logic [WB_COM_DWIDTH/8-1:0] wb_sel_i,
  input  logic                       wb_cyc_i,
  input  logic                       wb_stb_i,
  input  logic                       wb_we_i,
  output logic [WB_COM_DWIDTH-1:0]   wb_dat_o,
  output logic                       wb_stall_o,
  output logic                       wb_ack_o,
  output logic                       wb_err_o
);

  localparam int unsigned BYTES = WB_COM_DWIDTH / 8;
  localparam int unsigned OFFW  = $clog2(BYTES);
  localparam int unsigned IDXW  = $clog2(DEPTH);

  localparam logic [0:0] S_INIT = 1'(ST_INIT);
  localparam logic [0:0] S_RUN  = 1'(ST_RUN);

  logic [0:0]               r_state;
  logic [IDXW-1:0]          r_cnt;
  logic [WB_COM_DWIDTH-1:0] r_mem [DEPTH];

  logic                     w_stall;
  logic                     w_acc;
  logic [WB_COM_AWIDTH-1:0] w_off;
  logic [IDXW-1:0]          w_idx;
  logic                     w_oor;
  logic                     w_wr;
  logic                     w_flush;
  sram_rsp_t                w_stage_in;
  sram_rsp_t                w_stage_out;

  // Init-clear sequencer: one word per cycle, then run until reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_INIT;
      r_cnt   <= '0;
    end else if (r_state == S_INIT) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == IDXW'(DEPTH - 1)) begin
        r_state <= S_RUN;
      end
    end
  end

  assign w_stall = (r_state == S_INIT) | rst_i;
  assign w_acc   = wb_cyc_i & wb_stb_i & ~w_stall;
  assign w_off   = wb_adr_i - BASE_ADDR;
  assign w_idx   = w_off[OFFW +: IDXW];

`ifdef SELEN_WB_SRAM_ERR_EN
  assign w_oor = (w_off >= WB_COM_AWIDTH'(DEPTH * BYTES));
`else
  assign w_oor = 1'b0;
`endif

  assign w_wr = w_acc & wb_we_i & ~w_oor;

  // Clear writes take priority; no bus write can be accepted during INIT anyway.
  always_ff @(posedge clk_i) begin
    if (!rst_i && r_state == S_INIT) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wb_sel_i[b]) begin
          r_mem[w_idx][8*b +: 8] <= wb_dat_i[8*b +: 8];
        end
      end
    end
  end

  // Data is zero unless this is an in-window read, so idle stages carry 0.
  always_comb begin
    w_stage_in       = '0;
    w_stage_in.valid = w_acc;
    w_stage_in.err   = w_acc & w_oor;
    if (w_acc && !wb_we_i && !w_oor) begin
      w_stage_in.data = r_mem[w_idx];
    end
  end

  assign w_flush = ~wb_cyc_i | rst_i;

  selen_wb_sram_rsp_pipe #(
    .LATENCY (LATENCY)
  ) u_rsp_pipe (
    .i_clk   (clk_i),
    .i_flush (w_flush),
    .i_stage (w_stage_in),
    .o_stage (w_stage_out)
  );

  assign wb_stall_o = w_stall;
  assign wb_dat_o   = w_stage_out.data;
  assign wb_ack_o   = w_stage_out.valid & ~w_stage_out.err;
`ifdef SELEN_WB_SRAM_ERR_EN
  assign wb_err_o   = w_stage_out.valid & w_stage_out.err;
`else
  assign wb_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_selen_wb_sram_slave.sv
// Directed bench for selen_wb_sram_slave with default parameters.
// Expectations for the out-of-window cases follow SELEN_WB_SRAM_ERR_EN.
module tb_selen_wb_sram_slave;

  localparam int unsigned LAT  = 2;
  localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef SELEN_WB_SRAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic        cyc, stb, we;
  logic [31:0] rdat;
  logic        stall, ack, err;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  selen_wb_sram_slave dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wb_adr_i   (adr),
    .wb_dat_i   (wdat),
    .wb_sel_i   (sel),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_we_i    (we),
    .wb_dat_o   (rdat),
    .wb_stall_o (stall),
    .wb_ack_o   (ack),
    .wb_err_o   (err)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        ack;
    logic        err;
    logic [31:0] rd;
    string       name;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  // Called at a negedge; issues one request and checks its response window.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic eack, input logic eerr,
                        input logic [31:0] erd, input string nm);
    chk({nm, " stall"}, 32'(stall), 32'd0);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      stb = 1'b0; we = 1'b0;
      if (k < LAT) begin
        chk({nm, " early"}, {30'd0, ack, err}, 32'd0);
      end else begin
        chk({nm, " ack"}, 32'(ack), 32'(eack));
        chk({nm, " err"}, 32'(err), 32'(eerr));
        chk({nm, " dat"}, rdat, erd);
      end
    end
    cyc = 1'b0;
  endtask

  // Called at a negedge right after rst drops; counts stall-high cycles.
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (stall === 1'b1 && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cnt;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    adr = '0; wdat = '0; sel = '0;

    vecs[0]  = '{1'b0, BASE + 32'h10, 32'h0,         4'hf, 1'b1, 1'b0, 32'h0,         "rd_clear"};
    vecs[1]  = '{1'b1, BASE + 32'h04, 32'hDEADBEEF,  4'hf, 1'b1, 1'b0, 32'h0,         "wr_full"};
    vecs[2]  = '{1'b1, BASE + 32'h04, 32'h00000055,  4'h1, 1'b1, 1'b0, 32'h0,         "wr_byte0"};
    vecs[3]  = '{1'b0, BASE + 32'h04, 32'h0,         4'hf, 1'b1, 1'b0, 32'hDEADBE55,  "rd_merge"};
    vecs[4]  = '{1'b1, BASE + 32'h08, 32'h12345678,  4'h6, 1'b1, 1'b0, 32'h0,         "wr_mid"};
    vecs[5]  = '{1'b0, BASE + 32'h08, 32'h0,         4'hf, 1'b1, 1'b0, 32'h00345600,  "rd_mid"};
    vecs[6]  = '{1'b1, BASE + 32'h08, 32'hFFFFFFFF,  4'h0, 1'b1, 1'b0, 32'h0,         "wr_sel0"};
    vecs[7]  = '{1'b0, BASE + 32'h08, 32'h0,         4'hf, 1'b1, 1'b0, 32'h00345600,  "rd_sel0"};
    vecs[8]  = '{1'b0, BASE + 32'h06, 32'h0,         4'hf, 1'b1, 1'b0, 32'hDEADBE55,  "rd_lowbits"};
    vecs[9]  = '{1'b0, BASE + 32'h04, 32'h0,         4'h0, 1'b1, 1'b0, 32'hDEADBE55,  "rd_nosel"};
    vecs[10] = '{1'b1, BASE + 32'h400, 32'hA5A5A5A5, 4'hf, !ERR_EN, ERR_EN, 32'h0,    "wr_oor"};
    vecs[11] = '{1'b0, BASE,           32'h0,        4'hf, 1'b1, 1'b0,
                 ERR_EN ? 32'h0 : 32'hA5A5A5A5, "rd_word0"};
    vecs[12] = '{1'b0, BASE + 32'h400, 32'h0,        4'hf, !ERR_EN, ERR_EN,
                 ERR_EN ? 32'h0 : 32'hA5A5A5A5, "rd_oor"};
    vecs[13] = '{1'b0, BASE + 32'h3FC, 32'h0,        4'hf, 1'b1, 1'b0, 32'h0,         "rd_last"};

    // Reset state and init-clear duration.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst ack",   32'(ack),   32'd0);
    chk("rst err",   32'(err),   32'd0);
    chk("rst dat",   rdat,       32'd0);
    chk("rst stall", 32'(stall), 32'd1);
    rst = 1'b0;
    wait_ready(cnt);
    chk("init stall cycles", 32'(cnt), 32'd256);

    for (int i = 0; i < NV; i++) begin
      do_req(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel,
             vecs[i].ack, vecs[i].err, vecs[i].rd, vecs[i].name);
    end

    // Back-to-back reads of preloaded words 0..7.
    for (int i = 0; i < 8; i++) begin
      do_req(1'b1, BASE + 32'(4 * i), 32'(i), 4'hf, 1'b1, 1'b0, 32'h0, "preload");
    end
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hf; adr = BASE;
    for (int c = 1; c <= 8 + LAT; c++) begin
      @(negedge clk);
      chk("burst stall", 32'(stall), 32'd0);
      chk("burst ack", 32'(ack), 32'((c >= LAT) && (c < LAT + 8)));
      if (c >= LAT && c < LAT + 8) chk("burst dat", rdat, 32'(c - LAT));
      if (c < 8) adr = BASE + 32'(4 * c);
      else stb = 1'b0;
    end
    cyc = 1'b0;

    // Abort: write then drop cyc; read then drop cyc.
    for (int t = 0; t < 2; t++) begin
      cyc = 1'b1; stb = 1'b1; we = (t == 0); adr = BASE + 32'h20;
      wdat = 32'hCAFEF00D; sel = 4'hf;
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      for (int k = 0; k < 4; k++) begin
        chk("abort no resp", {30'd0, ack, err}, 32'd0);
        @(negedge clk);
      end
    end
    do_req(1'b0, BASE + 32'h20, 32'h0, 4'hf, 1'b1, 1'b0, 32'hCAFEF00D, "abort wr kept");

    // Reset with a read in flight and another pending.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h04;
    @(negedge clk);
    adr = BASE + 32'h08; rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst flush", {30'd0, ack, err}, 32'd0);
    end
    cyc = 1'b0; stb = 1'b0; rst = 1'b0;
    wait_ready(cnt);
    chk("reinit stall cycles", 32'(cnt), 32'd256);
    do_req(1'b0, BASE + 32'h04, 32'h0, 4'hf, 1'b1, 1'b0, 32'h0, "recleared w1");
    do_req(1'b0, BASE + 32'h08, 32'h0, 4'hf, 1'b1, 1'b0, 32'h0, "recleared w2");
    do_req(1'b0, BASE + 32'h1C, 32'h0, 4'hf, 1'b1, 1'b0, 32'h0, "recleared w7");
    do_req(1'b0, BASE + 32'h20, 32'h0, 4'hf, 1'b1, 1'b0, 32'h0, "recleared w8");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
